// File: rtl/dcache_ctrl_if.sv
// Bus bundle between dcache_ctrl and its CPU port, cache array and DRAM port.
interface dcache_ctrl_if #(
    parameter int DATA_W = 11,
    parameter int TAG_W  = 20,
    parameter int IDX_W  = 8
);
    logic                     cpu_req_valid;
    logic                     cpu_req_ready;
    logic                     cpu_req_we;
    logic [TAG_W-1:0]         cpu_req_tag;
    logic [IDX_W-1:0]         cpu_req_idx;
    logic [DATA_W-1:0]        cpu_req_wdata;
    logic                     cpu_resp_valid;
    logic [DATA_W-1:0]        cpu_resp_rdata;
    logic                     cpu_resp_hit;
    logic                     cpu_resp_err;
    logic [IDX_W-1:0]         arr_idx;
    logic [TAG_W-1:0]         arr_tag;
    logic                     arr_rd_en;
    logic                     arr_hit;
    logic [DATA_W-1:0]        arr_rdata;
    logic                     arr_wr_en;
    logic                     arr_fill_en;
    logic [DATA_W-1:0]        arr_wdata;
    logic                     mem_req;
    logic                     mem_we;
    logic [TAG_W+IDX_W-1:0]   mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ready;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     clr_stats;
    logic [15:0]              hit_cnt;
    logic [15:0]              miss_cnt;

    // Controller side
    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_req_tag, cpu_req_idx, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit, cpu_resp_err,
        output arr_idx, arr_tag, arr_rd_en, arr_wr_en, arr_fill_en, arr_wdata,
        input  arr_hit, arr_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        input  clr_stats,
        output hit_cnt, miss_cnt
    );

    // CPU / array / DRAM side
    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_req_tag, cpu_req_idx, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit, cpu_resp_err,
        input  arr_idx, arr_tag, arr_rd_en, arr_wr_en, arr_fill_en, arr_wdata,
        output arr_hit, arr_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        output clr_stats,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped data cache controller: lookup, write-through,
// read-miss fill from DRAM with timeout abort, saturating hit/miss stats.
module dcache_ctrl #(
    parameter int DATA_W  = 11,
    parameter int TAG_W   = 20,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst_n,
    dcache_ctrl_if.master bus
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP} state_t;

    state_t              state_q, state_d;
    logic                ready_q;
    logic                we_q, we_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                lk_hit_q, lk_hit_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    // Next-state, request latch and response field selection
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        lk_hit_d = lk_hit_q;
        fill_d   = fill_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        hit_d    = hit_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req_valid && ready_q) begin
                    we_d    = bus.cpu_req_we;
                    tag_d   = bus.cpu_req_tag;
                    idx_d   = bus.cpu_req_idx;
                    wdata_d = bus.cpu_req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lk_hit_d = bus.arr_hit;
                wait_d   = '0;
                if (we_q) begin
                    state_d = MEM_WR;
                end else if (bus.arr_hit) begin
                    state_d = RESP;
                    rdata_d = bus.arr_rdata;
                    hit_d   = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (bus.mem_ready) begin
                    fill_d  = bus.mem_rdata;
                    state_d = FILL;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                    hit_d   = lk_hit_q;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            FILL: begin
                state_d = RESP;
                rdata_d = fill_q;
                hit_d   = 1'b0;
                err_d   = 1'b0;
            end
            MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    rdata_d = '0;
                    hit_d   = lk_hit_q;
                    err_d   = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                    hit_d   = lk_hit_q;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating statistics; a clear wins over a same-cycle lookup
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.clr_stats) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (state_q == LOOKUP) begin
            if (bus.arr_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    // State and datapath registers; ready is registered so it stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            tag_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            lk_hit_q   <= 1'b0;
            fill_q     <= '0;
            wait_q     <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == IDLE);
            we_q       <= we_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            lk_hit_q   <= lk_hit_d;
            fill_q     <= fill_d;
            wait_q     <= wait_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.cpu_req_ready  = ready_q;
    assign bus.cpu_resp_valid = (state_q == RESP);
    assign bus.cpu_resp_rdata = rdata_q;
    assign bus.cpu_resp_hit   = hit_q;
    assign bus.cpu_resp_err   = err_q;
    assign bus.arr_idx        = idx_q;
    assign bus.arr_tag        = tag_q;
    assign bus.arr_rd_en      = (state_q == LOOKUP);
    // Write-hit update must land in the lookup cycle itself, so it follows arr_hit directly
    assign bus.arr_wr_en      = (state_q == LOOKUP) && we_q && bus.arr_hit;
    assign bus.arr_fill_en    = (state_q == FILL);
    assign bus.arr_wdata      = (state_q == FILL) ? fill_q : wdata_q;
    assign bus.mem_req        = (state_q == MEM_RD) || (state_q == MEM_WR);
    assign bus.mem_we         = (state_q == MEM_WR);
    assign bus.mem_addr       = {tag_q, idx_q};
    assign bus.mem_wdata      = wdata_q;
    assign bus.hit_cnt        = hit_cnt_q;
    assign bus.miss_cnt       = miss_cnt_q;
endmodule
